fpcomp_sp_arbiter: RTL and testbench

Shares one FloPoCo single-precision comparator (34-bit operands: 2 exception bits + sign + 8 exp + 23 mantissa) among NUM_REQ requesters, using round-robin arbitration. The block registers the granted operands, drives the external comparator instance and tracks each in-flight operation with a requester-ID pipeline matched to the comparator latency. It returns each result on a single response channel tagged with the requester ID. The comparator runs in a pipeline that the response channel can stall.

---
 rtl/fpcomp_sp_arbiter.sv | 150 +++++++++++++++
 tb/tb_fpcomp_sp_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fpcomp_sp_arbiter.sv
// Round-robin front end sharing one FloPoCo single-precision comparator.
// Tags each op with its requester ID and returns results in order.
module fpcomp_sp_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CMP_STAGES = 1,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*34-1:0] req_X,
    input  logic [NUM_REQ*34-1:0] req_Y,
    output logic                  cmp_ce,
    output logic [33:0]           cmp_X,
    output logic [33:0]           cmp_Y,
    input  logic                  cmp_unordered,
    input  logic                  cmp_XltY,
    input  logic                  cmp_XeqY,
    input  logic                  cmp_XleY,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_unordered,
    output logic                  rsp_XltY,
    output logic                  rsp_XeqY,
    output logic                  rsp_XleY,
    output logic                  busy
);

    if (CMP_STAGES != 0 && CMP_STAGES != 1) begin : g_bad_stages
        $error("fpcomp_sp_arbiter: CMP_STAGES must be 0 or 1");
    end

    logic                            adv;
    logic                            found;
    logic                            accept;
    logic [ID_W-1:0]                 grant;
    logic [ID_W:0]                   scan;
    logic [ID_W:0]                   nxt;
    logic [33:0]                     gx;
    logic [33:0]                     gy;

    logic [ID_W-1:0]                 ptr_q, ptr_d;
    logic [33:0]                     x_q, x_d;
    logic [33:0]                     y_q, y_d;
    logic [CMP_STAGES:0]             tv_q, tv_d;
    logic [CMP_STAGES:0][ID_W-1:0]   tid_q, tid_d;
    logic                            rv_q, rv_d;
    logic [ID_W-1:0]                 rid_q, rid_d;
    logic [3:0]                      fl_q, fl_d;

    // A held response freezes the whole pipe, comparator included.
    assign adv    = !(rv_q && !rsp_ready);
    assign cmp_ce = adv;

    always_comb begin
        found = 1'b0;
        grant = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ)) begin
                scan = scan - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[scan[ID_W-1:0]]) begin
                found = 1'b1;
                grant = scan[ID_W-1:0];
            end
        end
        accept = adv && found;
    end

    always_comb begin
        req_ready = '0;
        gx        = '0;
        gy        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                req_ready[i] = accept;
                gx           = req_X[34*i +: 34];
                gy           = req_Y[34*i +: 34];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        x_d   = x_q;
        y_d   = y_q;
        tv_d  = tv_q;
        tid_d = tid_q;
        rv_d  = rv_q;
        rid_d = rid_q;
        fl_d  = fl_q;
        nxt   = {1'b0, grant} + 1'b1;
        if (nxt == (ID_W+1)'(NUM_REQ)) begin
            nxt = '0;
        end
        if (adv) begin
            tv_d[0] = accept;
            if (accept) begin
                ptr_d    = nxt[ID_W-1:0];
                x_d      = gx;
                y_d      = gy;
                tid_d[0] = grant;
            end
            for (int s = 1; s <= CMP_STAGES; s++) begin
                tv_d[s]  = tv_q[s-1];
                tid_d[s] = tid_q[s-1];
            end
            rv_d  = tv_q[CMP_STAGES];
            rid_d = tid_q[CMP_STAGES];
            fl_d  = {cmp_unordered, cmp_XltY, cmp_XeqY, cmp_XleY};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            tv_q  <= '0;
            tid_q <= '0;
            rv_q  <= 1'b0;
            rid_q <= '0;
            fl_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            x_q   <= x_d;
            y_q   <= y_d;
            tv_q  <= tv_d;
            tid_q <= tid_d;
            rv_q  <= rv_d;
            rid_q <= rid_d;
            fl_q  <= fl_d;
        end
    end

    assign cmp_X         = x_q;
    assign cmp_Y         = y_q;
    assign rsp_valid     = rv_q;
    assign rsp_id        = rid_q;
    assign rsp_unordered = fl_q[3];
    assign rsp_XltY      = fl_q[2];
    assign rsp_XeqY      = fl_q[1];
    assign rsp_XleY      = fl_q[0];
    assign busy          = (|tv_q) | rv_q;

endmodule

// File: tb/tb_fpcomp_sp_arbiter.sv
// Directed bench: one DUT with a registered comparator model, one with a
// combinational comparator model, checked with immediate assertions.
module tb_fpcomp_sp_arbiter;

    localparam logic [33:0] ONE = 34'h13F800000;
    localparam logic [33:0] TWO = 34'h140000000;
    localparam logic [33:0] NAN = 34'h300000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [135:0] req_X = '0;
    logic [135:0] req_Y = '0;
    logic         rsp_ready = 1'b1;

    logic [3:0]  rr1, rr0;
    logic        ce1, ce0;
    logic [33:0] cx1, cy1, cx0, cy0;
    logic [3:0]  cf1_q = '0;
    logic [3:0]  cf0;
    logic        rv1, rv0, bz1, bz0;
    logic [1:0]  id1, id0;
    logic [3:0]  f1, f0;

    int vectors = 0;
    int errs = 0;
    logic [3:0] exp_f [4];

    always #5 clk = ~clk;

    // Reference comparator: {unordered, lt, eq, le}.
    function automatic logic signed [35:0] fkey(logic [33:0] a);
        logic signed [35:0] m;
        m = (a[33:32] == 2'b00) ? 36'sd0 : $signed({3'b000, a[33:32], a[30:0]});
        return a[31] ? -m : m;
    endfunction

    function automatic logic [3:0] fcmp(logic [33:0] a, logic [33:0] b);
        logic lt, eq;
        if (a[33:32] == 2'b11 || b[33:32] == 2'b11) return 4'b1000;
        lt = fkey(a) < fkey(b);
        eq = fkey(a) == fkey(b);
        return {1'b0, lt, eq, lt | eq};
    endfunction

    always @(posedge clk) if (ce1) cf1_q <= fcmp(cx1, cy1);
    assign cf0 = fcmp(cx0, cy0);

    fpcomp_sp_arbiter #(.NUM_REQ(4), .CMP_STAGES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rr1),
        .req_X(req_X), .req_Y(req_Y),
        .cmp_ce(ce1), .cmp_X(cx1), .cmp_Y(cy1),
        .cmp_unordered(cf1_q[3]), .cmp_XltY(cf1_q[2]),
        .cmp_XeqY(cf1_q[1]), .cmp_XleY(cf1_q[0]),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(id1),
        .rsp_unordered(f1[3]), .rsp_XltY(f1[2]),
        .rsp_XeqY(f1[1]), .rsp_XleY(f1[0]),
        .busy(bz1)
    );

    fpcomp_sp_arbiter #(.NUM_REQ(4), .CMP_STAGES(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rr0),
        .req_X(req_X), .req_Y(req_Y),
        .cmp_ce(ce0), .cmp_X(cx0), .cmp_Y(cy0),
        .cmp_unordered(cf0[3]), .cmp_XltY(cf0[2]),
        .cmp_XeqY(cf0[1]), .cmp_XleY(cf0[0]),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_id(id0),
        .rsp_unordered(f0[3]), .rsp_XltY(f0[2]),
        .rsp_XeqY(f0[1]), .rsp_XleY(f0[0]),
        .busy(bz0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [33:0] x, input logic [33:0] y);
        req_X[34*i +: 34] = x;
        req_Y[34*i +: 34] = y;
    endtask

    task automatic single(input int i, input logic [33:0] x, input logic [33:0] y,
                          input logic [3:0] ef, input string nm);
        set_op(i, x, y);
        req_valid = 4'b0001 << i;
        #1;
        chk({nm, "_grant"}, rr1, 4'b0001 << i);
        step();
        req_valid = '0;
        #1;
        chk({nm, "_t1_v"}, rv1, 0);
        chk({nm, "_t1_cmpx"}, cx1, x);
        chk({nm, "_t1_busy"}, bz1, 1);
        chk({nm, "_t1_v0"}, rv0, 0);
        step();
        chk({nm, "_s0_v"}, rv0, 1);
        chk({nm, "_s0_id"}, id0, i);
        chk({nm, "_s0_f"}, f0, ef);
        chk({nm, "_t2_v"}, rv1, 0);
        step();
        chk({nm, "_s1_v"}, rv1, 1);
        chk({nm, "_s1_id"}, id1, i);
        chk({nm, "_s1_f"}, f1, ef);
        chk({nm, "_s0_gone"}, rv0, 0);
        step();
        chk({nm, "_done_v"}, rv1, 0);
        chk({nm, "_done_busy"}, bz1, 0);
    endtask

    initial begin
        #12;
        chk("rst_rsp_valid", rv1, 0);
        chk("rst_rsp_id", id1, 0);
        chk("rst_flags", f1, 0);
        chk("rst_cmp_x", cx1, 0);
        chk("rst_busy", bz1, 0);
        chk("rst_req_ready", rr1, 0);
        rst_n = 1'b1;
        step();

        single(0, ONE, TWO, 4'b0101, "lt");
        single(1, ONE, ONE, 4'b0011, "eq");
        single(2, NAN, ONE, 4'b1000, "nan");

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_op(0, ONE, TWO); exp_f[0] = 4'b0101;
        set_op(1, ONE, ONE); exp_f[1] = 4'b0011;
        set_op(2, NAN, ONE); exp_f[2] = 4'b1000;
        set_op(3, TWO, ONE); exp_f[3] = 4'b0000;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", rr1, 4'b0001 << (k % 4));
            if (k >= 3) begin
                chk("rr_rsp_v", rv1, 1);
                chk("rr_rsp_id", id1, (k - 3) % 4);
                chk("rr_rsp_f", f1, exp_f[(k - 3) % 4]);
            end else begin
                chk("rr_rsp_idle", rv1, 0);
            end
            step();
        end

        rsp_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("bp_v", rv1, 1);
            chk("bp_id", id1, 1);
            chk("bp_f", f1, exp_f[1]);
            chk("bp_ce", ce1, 0);
            chk("bp_ready", rr1, 0);
            if (j < 4) step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        chk("bp_r1_v", rv1, 1);
        chk("bp_r1_id", id1, 2);
        chk("bp_r1_f", f1, exp_f[2]);
        step();
        chk("bp_r2_v", rv1, 1);
        chk("bp_r2_id", id1, 3);
        chk("bp_r2_f", f1, exp_f[3]);
        step();
        chk("bp_end_v", rv1, 0);
        chk("bp_end_busy", bz1, 0);

        req_valid = 4'b1100;
        #1;
        chk("mr_grant2", rr1, 4'b0100);
        step();
        chk("mr_grant3", rr1, 4'b1000);
        step();
        req_valid = '0;
        #1;
        chk("mr_busy", bz1, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_busy", bz1, 0);
        chk("mr_rst_v", rv1, 0);
        chk("mr_rst_cmpx", cx1, 0);
        chk("mr_rst_id", id1, 0);
        step();
        rst_n = 1'b1;
        req_valid = 4'b0110;
        #1;
        chk("mr_regrant", rr1, 4'b0010);
        step();
        req_valid = '0;
        chk("mr_nostale1", rv1, 0);
        step();
        chk("mr_nostale2", rv1, 0);
        step();
        chk("mr_rsp_v", rv1, 1);
        chk("mr_rsp_id", id1, 1);
        chk("mr_rsp_f", f1, exp_f[1]);
        step();
        chk("mr_end_v", rv1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
